// File: rtl/ps2_keyboard_pkg.sv
// Shared definitions for the PS/2 receive path: frame length, FSM states and status bit layout.
package ps2_keyboard_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    localparam int STAT_READY = 0;
    localparam int STAT_OVF   = 1;
    localparam int STAT_PERR  = 2;

endpackage

// File: rtl/ps2_keyboard_if.sv
// CPU-side port-read bundle of the keyboard receiver: pop/clear strobes in, FIFO head and flags out.
interface ps2_keyboard_if;

    logic       rd;
    logic       clr;
    logic [7:0] q;
    logic       ready;
    logic       ovf;
    logic       perr;
    logic [7:0] status;

    modport master (
        output rd, clr,
        input  q, ready, ovf, perr, status
    );

    modport slave (
        input  rd, clr,
        output q, ready, ovf, perr, status
    );

endinterface

// File: rtl/ps2_fifo.sv
// Small circular byte FIFO shared by the keyboard and mouse receivers.
module ps2_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic [FIFO_AW:0] count,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               doPush, doPop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (FIFO_AW + 1)'(DEPTH));

    // A pop frees the slot in the same edge, so a full FIFO may still accept a push then.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q] <= din;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign dout  = empty ? 8'h00 : mem_q[rdPtr_q];
    assign count = count_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames and queues scan codes.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 12500
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ps2_clk,
    input  logic          ps2_dat,
    ps2_keyboard_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT);

    logic [1:0]                clkSync_q, datSync_q;
    logic                      clkPrev_q;
    logic                      fall, bitIn;
    ps2_state_e                state_q, state_d;
    logic [3:0]                bitCnt_q, bitCnt_d, bitCntInc;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [PS2_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                      frameOk, pushReq, frameErr;
    logic                      popReq, overflow;
    logic                      ovf_q, perr_q;
    logic [7:0]                fifoHead;
    logic [FIFO_AW:0]          fifoCount;
    logic                      fifoFull, fifoEmpty;

    // Idle-high presets keep a reset release from looking like a clock fall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
            clkPrev_q <= 1'b1;
        end else begin
            clkSync_q <= {clkSync_q[0], ps2_clk};
            datSync_q <= {datSync_q[0], ps2_dat};
            clkPrev_q <= clkSync_q[1];
        end
    end

    assign fall      = clkPrev_q & ~clkSync_q[1];
    assign bitIn     = datSync_q[1];
    assign bitCntInc = bitCnt_q + 4'd1;

    // Bits arrive LSB-first: start ends in [0], data in [8:1], parity [9], stop [10].
    assign frameOk = ~shreg_q[0] & shreg_q[10] & (^shreg_q[9:1]);

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        tmo_d    = tmo_q;
        shreg_d  = shreg_q;
        pushReq  = 1'b0;
        frameErr = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    shreg_d  = {bitIn, {(PS2_FRAME_BITS-1){1'b0}}};
                    bitCnt_d = 4'd1;
                    tmo_d    = '0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (fall) begin
                    shreg_d  = {bitIn, shreg_q[PS2_FRAME_BITS-1:1]};
                    bitCnt_d = bitCntInc;
                    tmo_d    = '0;
                    if (bitCntInc == 4'(PS2_FRAME_BITS)) state_d = CHECK;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                pushReq  = frameOk;
                frameErr = ~frameOk;
                state_d  = IDLE;
                // A fall here already belongs to the next frame's start bit.
                if (fall) begin
                    shreg_d  = {bitIn, {(PS2_FRAME_BITS-1){1'b0}}};
                    bitCnt_d = 4'd1;
                    tmo_d    = '0;
                    state_d  = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            tmo_q    <= '0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            tmo_q    <= tmo_d;
            shreg_q  <= shreg_d;
        end
    end

    assign popReq   = bus.rd & ~fifoEmpty;
    assign overflow = pushReq & fifoFull & ~popReq;

    // Sticky flags: a new event in the same cycle as clr keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (overflow)     ovf_q <= 1'b1;
            else if (bus.clr) ovf_q <= 1'b0;
            if (frameErr)     perr_q <= 1'b1;
            else if (bus.clr) perr_q <= 1'b0;
        end
    end

    ps2_fifo #(.FIFO_AW(FIFO_AW)) uFifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (pushReq),
        .din     (shreg_q[8:1]),
        .pop     (popReq),
        .dout    (fifoHead),
        .count   (fifoCount),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    assign bus.q     = fifoHead;
    assign bus.ready = (fifoCount != '0);
    assign bus.ovf   = ovf_q;
    assign bus.perr  = perr_q;

    always_comb begin
        bus.status             = 8'h00;
        bus.status[STAT_READY] = (fifoCount != '0);
        bus.status[STAT_OVF]   = ovf_q;
        bus.status[STAT_PERR]  = perr_q;
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: bit-level PS/2 device driver, table vectors, corner sequences and a queue model.
module tb_ps2_keyboard;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 12500;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_keyboard_if bus ();

    ps2_keyboard #(.FIFO_AW(3), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: a byte queue of at most 8 entries plus the two sticky flags.
    logic [7:0] mq[$];
    logic       mOvf = 1'b0;
    logic       mPerr = 1'b0;

    // kind: 0 valid, 1 bad parity, 2 bad start, 3 bad stop
    typedef struct {
        logic [7:0] data;
        int         kind;
        logic       doRead;
        logic       doClr;
        logic [7:0] expQ;
        logic [7:0] expStatus;
    } vec_t;

    vec_t vecs[6];

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, actual, expected);
        end
    endtask

    function automatic logic [10:0] buildFrame(input logic [7:0] data, input int kind);
        logic [10:0] f;
        f[0]   = (kind == 2);
        f[8:1] = data;
        f[9]   = ~(^data) ^ (kind == 1);
        f[10]  = (kind != 3);
        return f;
    endfunction

    task automatic modelFrame(input logic [7:0] data, input int kind);
        if (kind != 0)            mPerr = 1'b1;
        else if (mq.size() == 8)  mOvf = 1'b1;
        else                      mq.push_back(data);
    endtask

    task automatic sendBit(input logic b);
        ps2_dat = b;
        waitClocks(HALF);
        ps2_clk = 1'b0;
        waitClocks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input int kind, input int nBits,
                             input int pauseAt, input int pauseLen);
        logic [10:0] f;
        f = buildFrame(data, kind);
        for (int i = 0; i < nBits; i++) begin
            sendBit(f[i]);
            if (i == pauseAt) waitClocks(pauseLen);
        end
        ps2_dat = 1'b1;
        waitClocks(8);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int kind);
        sendFrame(data, kind, 11, -1, 0);
        modelFrame(data, kind);
    endtask

    task automatic doRead();
        bus.rd = 1'b1;
        waitClocks(1);
        bus.rd = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic doClr();
        bus.clr = 1'b1;
        waitClocks(1);
        bus.clr = 1'b0;
        mOvf  = 1'b0;
        mPerr = 1'b0;
    endtask

    task automatic doReset();
        bus.rd  = 1'b0;
        bus.clr = 1'b0;
        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        waitClocks(4);
        reset_n = 1'b1;
        waitClocks(2);
        mq.delete();
        mOvf  = 1'b0;
        mPerr = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        logic [7:0] expQ;
        logic       expReady;
        expReady = (mq.size() != 0);
        expQ     = expReady ? mq[0] : 8'h00;
        checkOutput({tag, " q"},      bus.q,               expQ);
        checkOutput({tag, " ready"},  {7'b0, bus.ready},   {7'b0, expReady});
        checkOutput({tag, " ovf"},    {7'b0, bus.ovf},     {7'b0, mOvf});
        checkOutput({tag, " perr"},   {7'b0, bus.perr},    {7'b0, mPerr});
        checkOutput({tag, " status"}, bus.status,          {5'b0, mPerr, mOvf, expReady});
    endtask

    // Drives the first ten bits, then leaves the stop-bit fall on the pin for the caller to time against.
    task automatic driveUntilStopFall(input logic [7:0] data);
        sendFrame(data, 0, 10, -1, 0);
        ps2_dat = 1'b1;
        waitClocks(HALF);
        ps2_clk = 1'b0;
    endtask

    task automatic finishStop();
        waitClocks(HALF);
        ps2_clk = 1'b1;
        waitClocks(4);
    endtask

    initial begin
        logic [7:0] rdata;
        int         kind;
        int         act;

        bus.rd  = 1'b0;
        bus.clr = 1'b0;

        vecs[0] = '{8'h1C, 0, 1'b0, 1'b0, 8'h1C, 8'h01};
        vecs[1] = '{8'h55, 0, 1'b1, 1'b0, 8'h55, 8'h01};
        vecs[2] = '{8'h1C, 1, 1'b0, 1'b0, 8'h55, 8'h05};
        vecs[3] = '{8'h00, 2, 1'b1, 1'b1, 8'h00, 8'h00};
        vecs[4] = '{8'hA5, 3, 1'b0, 1'b0, 8'h00, 8'h04};
        vecs[5] = '{8'hFF, 0, 1'b0, 1'b1, 8'hFF, 8'h01};

        doReset();
        checkAll("reset");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, vecs[i].kind);
            if (vecs[i].doRead) doRead();
            if (vecs[i].doClr)  doClr();
            waitClocks(1);
            checkOutput($sformatf("vec%0d q", i),      bus.q,      vecs[i].expQ);
            checkOutput($sformatf("vec%0d status", i), bus.status, vecs[i].expStatus);
        end

        // Push latency: not visible 3 clocks after the stop-bit fall, visible after 4.
        doReset();
        driveUntilStopFall(8'h1C);
        repeat (3) @(posedge clock);
        #1 checkOutput("latency early ready", {7'b0, bus.ready}, 8'h00);
        @(posedge clock);
        #1 checkOutput("latency ready", {7'b0, bus.ready}, 8'h01);
        checkOutput("latency q", bus.q, 8'h1C);
        modelFrame(8'h1C, 0);
        finishStop();
        checkAll("latency");
        doRead();
        checkAll("latency read");

        // Overflow: nine frames, eight stored, ninth dropped.
        doReset();
        for (int d = 1; d <= 9; d++) applyStimulus(8'(d), 0);
        checkAll("ovf full");
        for (int k = 1; k <= 8; k++) begin
            rdata = 8'(k);
            checkOutput($sformatf("ovf read%0d", k), bus.q, rdata);
            doRead();
        end
        waitClocks(1);
        checkAll("ovf drained");

        // Full FIFO with rd landing on the push edge: both happen, no overflow.
        doReset();
        for (int d = 1; d <= 8; d++) applyStimulus(8'(d), 0);
        driveUntilStopFall(8'h0A);
        repeat (3) @(posedge clock);
        @(negedge clock);
        bus.rd = 1'b1;
        @(negedge clock);
        bus.rd = 1'b0;
        void'(mq.pop_front());
        mq.push_back(8'h0A);
        finishStop();
        checkAll("simul");
        for (int k = 0; k < 8; k++) begin
            rdata = (k == 7) ? 8'h0A : 8'(k + 2);
            checkOutput($sformatf("simul read%0d", k), bus.q, rdata);
            doRead();
        end
        waitClocks(1);
        checkAll("simul drained");

        // Stalled partial frame is dropped silently; a pause just short of the limit is not.
        doReset();
        sendFrame(8'hAA, 0, 5, -1, 0);
        waitClocks(TIMEOUT + 100);
        applyStimulus(8'hF0, 0);
        checkAll("timeout");
        sendFrame(8'h3C, 0, 11, 4, TIMEOUT - 100);
        modelFrame(8'h3C, 0);
        checkAll("long pause");

        // Reset in the middle of a frame.
        doReset();
        applyStimulus(8'h33, 0);
        applyStimulus(8'h44, 1);
        checkAll("pre reset");
        sendFrame(8'h12, 0, 6, -1, 0);
        doReset();
        checkAll("mid reset");
        applyStimulus(8'h5A, 0);
        checkAll("after reset");
        doRead();
        waitClocks(1);
        checkAll("after reset read");

        for (int n = 0; n < 15; n++) begin
            kind = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
            applyStimulus(8'($urandom), kind);
            checkAll($sformatf("rand%0d frame", n));
            act = int'($urandom_range(0, 3));
            if (act == 1 || act == 3) doRead();
            if (act == 3) doRead();
            if (act == 2) doClr();
            waitClocks(1);
            checkAll($sformatf("rand%0d act", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
